// File: rtl/run_controller.sv
// Run/step/halt sequencer that gates the CPU clock enable and holds the CPU in reset.
// Define RUN_CONTROLLER_WATCHDOG_EN to add a WDT_LIMIT-cycle watchdog on free-running execution.
module run_controller #(
  parameter int ERR_W      = 2,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2
`ifdef RUN_CONTROLLER_WATCHDOG_EN
  , parameter int WDT_LIMIT = 1_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] step_count,
  input  logic             cpu_stop,
  input  logic [ERR_W-1:0] cpu_error,
  output logic             cpu_run,
  output logic             cpu_reset,
  output logic [2:0]       state,
  output logic [2:0]       halt_cause,
  output logic [ERR_W-1:0] error_latched,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    HALTED     = 3'd1,
    RUNNING    = 3'd2,
    STEPPING   = 3'd3,
    FAULT      = 3'd4
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_HALT  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam logic [2:0] CAUSE_NONE      = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
  localparam logic [2:0] CAUSE_ERROR     = 3'd2;
  localparam logic [2:0] CAUSE_HOST      = 3'd3;
  localparam logic [2:0] CAUSE_STEP_DONE = 3'd4;
`ifdef RUN_CONTROLLER_WATCHDOG_EN
  localparam logic [2:0] CAUSE_WATCHDOG  = 3'd5;
  localparam int         WDT_W           = $clog2(WDT_LIMIT + 1);
`endif

  localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [2:0]       cause_q, cause_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             cmd_fire;
`ifdef RUN_CONTROLLER_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;
`endif

  // All outputs decode from registered state only, so no input reaches them combinationally.
  assign cpu_run       = (state_q == RUNNING) || (state_q == STEPPING);
  assign cpu_reset     = (state_q == RESET_HOLD);
  assign cmd_ready     = (state_q != RESET_HOLD);
  assign state         = state_q;
  assign halt_cause    = cause_q;
  assign error_latched = err_q;
  assign cycle_count   = cycle_q;
  assign cmd_fire      = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    steps_d = steps_q;
    cycle_d = cycle_q;
    cause_d = cause_q;
    err_d   = err_q;

    if (cpu_run && (cycle_q != '1)) cycle_d = cycle_q + CNT_W'(1);

    // Event priority while executing: error, then EBREAK, then host HALT/RUN, then step expiry.
    if (cmd_fire && (cmd_op == OP_RESET)) begin
      state_d = RESET_HOLD;
      hold_d  = HOLD_INIT;
      steps_d = '0;
      cycle_d = '0;
      cause_d = CAUSE_NONE;
      err_d   = '0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (hold_q <= 8'd1) state_d = HALTED;
          else                hold_d  = hold_q - 8'd1;
        end
        HALTED: begin
          if (cmd_fire && (cmd_op == OP_RUN)) begin
            state_d = RUNNING;
            cause_d = CAUSE_NONE;
          end else if (cmd_fire && (cmd_op == OP_STEP) && (step_count != '0)) begin
            state_d = STEPPING;
            steps_d = step_count;
            cause_d = CAUSE_NONE;
          end
        end
        RUNNING, STEPPING: begin
          if (cpu_error != '0) begin
            state_d = FAULT;
            cause_d = CAUSE_ERROR;
            err_d   = cpu_error;
          end else if (cpu_stop) begin
            state_d = HALTED;
            cause_d = CAUSE_EBREAK;
`ifdef RUN_CONTROLLER_WATCHDOG_EN
          end else if ((state_q == RUNNING) && (wdt_q == WDT_W'(WDT_LIMIT - 1))) begin
            state_d = FAULT;
            cause_d = CAUSE_WATCHDOG;
`endif
          end else if (cmd_fire && (cmd_op == OP_HALT)) begin
            state_d = HALTED;
            cause_d = CAUSE_HOST;
          end else if (cmd_fire && (cmd_op == OP_RUN)) begin
            state_d = RUNNING;
            cause_d = CAUSE_NONE;
          end else if (state_q == STEPPING) begin
            if (steps_q <= CNT_W'(1)) begin
              state_d = HALTED;
              cause_d = CAUSE_STEP_DONE;
            end else begin
              steps_d = steps_q - CNT_W'(1);
            end
          end
        end
        FAULT: ;
        default: state_d = RESET_HOLD;
      endcase
    end
  end

`ifdef RUN_CONTROLLER_WATCHDOG_EN
  // Counts consecutive free-running cycles; any exit from RUNNING restarts it.
  always_comb begin
    wdt_d = '0;
    if ((state_q == RUNNING) && (state_d == RUNNING)) wdt_d = wdt_q + WDT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdt_q <= '0;
    else          wdt_q <= wdt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_HOLD;
      hold_q  <= HOLD_INIT;
      steps_q <= '0;
      cycle_q <= '0;
      cause_q <= CAUSE_NONE;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      steps_q <= steps_d;
      cycle_q <= cycle_d;
      cause_q <= cause_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller in its default (no watchdog) build.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] step_count;
  logic        cpu_stop;
  logic [1:0]  cpu_error;
  logic        cpu_run;
  logic        cpu_reset;
  logic [2:0]  state;
  logic [2:0]  halt_cause;
  logic [1:0]  error_latched;
  logic [31:0] cycle_count;

  int checks   = 0;
  int failures = 0;
  int run_seen;

  run_controller #(.ERR_W(2), .CNT_W(32), .RST_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .step_count(step_count), .cpu_stop(cpu_stop), .cpu_error(cpu_error),
    .cpu_run(cpu_run), .cpu_reset(cpu_reset), .state(state), .halt_cause(halt_cause),
    .error_latched(error_latched), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle command strobe; the command takes effect on this edge.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] count);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    step_count = count;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; step_count = '0;
    cpu_stop = 1'b0; cpu_error = 2'b01;
    #2;
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("rst_cpu_run", 32'(cpu_run), 32'd0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_output("hold_edge1_state", 32'(state), 32'd0);
    check_output("hold_edge1_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check_output("hold_done_state", 32'(state), 32'd1);
    check_output("hold_done_cpu_reset", 32'(cpu_reset), 32'd0);
    check_output("hold_done_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("hold_done_cycles", cycle_count, 32'd0);
    check_output("hold_err_suppressed", 32'(error_latched), 32'd0);
    cpu_error = 2'b00;

    // STEP 5
    apply_stimulus(2'd1, 32'd5);
    run_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_run) run_seen++;
      tick();
    end
    check_output("step5_run_cycles", 32'(run_seen), 32'd5);
    check_output("step5_state", 32'(state), 32'd1);
    check_output("step5_cause", 32'(halt_cause), 32'd4);
    check_output("step5_cycles", cycle_count, 32'd5);

    // Host RESET clears counters and re-enters the hold
    apply_stimulus(2'd3, 32'd0);
    check_output("hostrst_state", 32'(state), 32'd0);
    check_output("hostrst_cycles", cycle_count, 32'd0);
    check_output("hostrst_cause", 32'(halt_cause), 32'd0);
    tick(); tick();
    check_output("hostrst_halted", 32'(state), 32'd1);

    // RUN, EBREAK on the 10th run cycle
    apply_stimulus(2'd0, 32'd0);
    check_output("run_cpu_run", 32'(cpu_run), 32'd1);
    check_output("run_cause_clear", 32'(halt_cause), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    cpu_stop = 1'b1;
    tick();
    cpu_stop = 1'b0;
    check_output("ebreak_state", 32'(state), 32'd1);
    check_output("ebreak_cause", 32'(halt_cause), 32'd1);
    check_output("ebreak_cycles", cycle_count, 32'd10);
    tick(); tick();
    check_output("ebreak_run_low", 32'(cpu_run), 32'd0);
    check_output("ebreak_cycles_hold", cycle_count, 32'd10);

    // Error and stop on the same edge: error wins
    apply_stimulus(2'd0, 32'd0);
    tick(); tick();
    cpu_error = 2'b10; cpu_stop = 1'b1;
    tick();
    cpu_error = 2'b00; cpu_stop = 1'b0;
    check_output("fault_state", 32'(state), 32'd4);
    check_output("fault_cause", 32'(halt_cause), 32'd2);
    check_output("fault_err", 32'(error_latched), 32'h2);
    check_output("fault_cycles", cycle_count, 32'd13);
    check_output("fault_cpu_run", 32'(cpu_run), 32'd0);
    check_output("fault_cmd_ready", 32'(cmd_ready), 32'd1);
    apply_stimulus(2'd0, 32'd0);
    check_output("fault_run_ignored", 32'(state), 32'd4);
    apply_stimulus(2'd1, 32'd3);
    check_output("fault_step_ignored", 32'(state), 32'd4);
    apply_stimulus(2'd3, 32'd0);
    tick(); tick();
    check_output("fault_recover_state", 32'(state), 32'd1);
    check_output("fault_recover_err", 32'(error_latched), 32'd0);
    check_output("fault_recover_cause", 32'(halt_cause), 32'd0);

    // Host HALT while running
    apply_stimulus(2'd0, 32'd0);
    tick(); tick();
    apply_stimulus(2'd2, 32'd0);
    check_output("halt_state", 32'(state), 32'd1);
    check_output("halt_cause_host", 32'(halt_cause), 32'd3);
    check_output("halt_cycles", cycle_count, 32'd3);
    tick();
    check_output("halt_no_more_run", cycle_count, 32'd3);

    // RUN while stepping converts to free run
    apply_stimulus(2'd1, 32'd100);
    apply_stimulus(2'd0, 32'd0);
    check_output("step_to_run_state", 32'(state), 32'd2);
    apply_stimulus(2'd2, 32'd0);
    check_output("step_to_run_cycles", cycle_count, 32'd5);

    // STEP 0 is a no-op
    apply_stimulus(2'd1, 32'd0);
    check_output("step0_state", 32'(state), 32'd1);
    check_output("step0_cause", 32'(halt_cause), 32'd3);
    check_output("step0_cycles", cycle_count, 32'd5);

    // EBREAK beats host HALT on the same edge
    apply_stimulus(2'd0, 32'd0);
    cpu_stop = 1'b1;
    apply_stimulus(2'd2, 32'd0);
    cpu_stop = 1'b0;
    check_output("stop_vs_halt_cause", 32'(halt_cause), 32'd1);
    check_output("stop_vs_halt_cycles", cycle_count, 32'd6);

    // Host HALT beats step expiry on the same edge
    apply_stimulus(2'd1, 32'd2);
    tick();
    apply_stimulus(2'd2, 32'd0);
    check_output("halt_vs_expiry_cause", 32'(halt_cause), 32'd3);
    check_output("halt_vs_expiry_cycles", cycle_count, 32'd8);

    // Async reset mid-STEP
    apply_stimulus(2'd1, 32'd10);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check_output("async_state", 32'(state), 32'd0);
    check_output("async_cpu_run", 32'(cpu_run), 32'd0);
    check_output("async_cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("async_cycles", cycle_count, 32'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check_output("async_rel_state", 32'(state), 32'd1);
    tick(); tick();
    check_output("async_step_discarded", 32'(cpu_run), 32'd0);
    check_output("async_rel_cycles", cycle_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
